// File: rtl/i2s_capture_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : i2s_capture_ctrl
//  Description : Single-session capture sequencer for the EF_I2S receiver.
//                Enables the I2S clock generator, flushes the receive FIFO,
//                optionally waits for the averaging flag, then moves exactly
//                cfg_len samples from the FIFO to a word memory (req/gnt).
//  Revision    : 1.0 - initial release
// ============================================================================
module i2s_capture_ctrl #(
  parameter int DW     = 32,
  parameter int BUF_AW = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start_i,
  input  logic              abort_i,
  input  logic              cfg_trig_en_i,
  input  logic [BUF_AW-1:0] cfg_len_i,
  output logic              i2s_en_o,
  output logic              fifo_flush_o,
  output logic              fifo_rd_o,
  input  logic              fifo_empty_i,
  input  logic              fifo_full_i,
  input  logic [DW-1:0]     fifo_rdata_i,
  input  logic              avg_flag_i,
  output logic              mem_req_o,
  output logic [BUF_AW-1:0] mem_addr_o,
  output logic [DW-1:0]     mem_wdata_o,
  input  logic              mem_gnt_i,
  output logic              busy_o,
  output logic              done_o,
  output logic              overrun_o,
  output logic [BUF_AW:0]   wr_count_o
);

  // Session length used when cfg_len is 0 (the whole buffer).
  localparam logic [BUF_AW:0] c_max_len = {1'b1, {BUF_AW{1'b0}}};

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_FLUSH   = 3'd1,
    S_ARMED   = 3'd2,
    S_CAPTURE = 3'd3,
    S_DONE    = 3'd4
  } state_t;

  state_t              state_q, state_d;
  logic [BUF_AW-1:0]   len_q, len_d;
  logic                trig_q, trig_d;
  logic                mem_req_q, mem_req_d;
  logic [BUF_AW-1:0]   mem_addr_q, mem_addr_d;
  logic [DW-1:0]       mem_wdata_q, mem_wdata_d;
  logic [BUF_AW:0]     wr_count_q, wr_count_d;
  logic                overrun_q, overrun_d;

  logic                w_accept;   // start taken in IDLE
  logic                w_gnt;      // write accepted this cycle
  logic [BUF_AW:0]     w_cnt_after;
  logic [BUF_AW:0]     w_target;
  logic                w_load;     // pop FIFO head into the write register
  logic                w_last;     // gnt that completes the session

  assign w_accept    = (state_q == S_IDLE) & start_i & ~abort_i;
  assign w_gnt       = mem_req_q & mem_gnt_i;
  assign w_cnt_after = wr_count_q + {{BUF_AW{1'b0}}, w_gnt};
  assign w_target    = (len_q == '0) ? c_max_len : {1'b0, len_q};
  // A sample is only loaded if the write slot frees up this cycle and more
  // writes are still owed once the in-flight gnt is accounted for. Abort
  // suppresses loading so no sample is popped and then dropped.
  assign w_load      = (state_q == S_CAPTURE) & ~abort_i & ~fifo_empty_i &
                       (~mem_req_q | mem_gnt_i) & (w_cnt_after < w_target);
  assign w_last      = (state_q == S_CAPTURE) & w_gnt & (w_cnt_after == w_target);

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic; abort overrides every non-IDLE transition.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:    if (w_accept)   state_d = S_FLUSH;
      S_FLUSH:   state_d = trig_q ? S_ARMED : S_CAPTURE;
      S_ARMED:   if (avg_flag_i) state_d = S_CAPTURE;
      S_CAPTURE: if (w_last)     state_d = S_DONE;
      S_DONE:    state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
    if (abort_i && (state_q != S_IDLE)) state_d = S_IDLE;
  end

  // Datapath next values: session config, write port, counters, overrun.
  always_comb begin
    len_d       = len_q;
    trig_d      = trig_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    wr_count_d  = wr_count_q;
    overrun_d   = overrun_q;
    if (w_accept) begin
      len_d      = cfg_len_i;
      trig_d     = cfg_trig_en_i;
      mem_addr_d = '0;
      wr_count_d = '0;
      overrun_d  = 1'b0;
    end
    if (w_gnt) begin
      mem_addr_d = mem_addr_q + 1'b1;
      wr_count_d = w_cnt_after;
    end
    if (w_load) mem_wdata_d = fifo_rdata_i;
    // Request stays up while ungranted; abort or leaving CAPTURE drops it.
    mem_req_d = w_load | (mem_req_q & ~mem_gnt_i);
    if (abort_i || (state_q != S_CAPTURE)) mem_req_d = 1'b0;
    if (((state_q == S_ARMED) || (state_q == S_CAPTURE)) && fifo_full_i)
      overrun_d = 1'b1;
  end

  // Datapath registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      len_q       <= '0;
      trig_q      <= 1'b0;
      mem_req_q   <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      wr_count_q  <= '0;
      overrun_q   <= 1'b0;
    end else begin
      len_q       <= len_d;
      trig_q      <= trig_d;
      mem_req_q   <= mem_req_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      wr_count_q  <= wr_count_d;
      overrun_q   <= overrun_d;
    end
  end

  assign i2s_en_o     = (state_q == S_ARMED) | (state_q == S_CAPTURE);
  assign fifo_flush_o = (state_q == S_FLUSH);
  assign fifo_rd_o    = w_load |
                        ((state_q == S_ARMED) & ~fifo_empty_i & ~abort_i);
  assign busy_o       = (state_q != S_IDLE);
  assign done_o       = (state_q == S_DONE);
  assign mem_req_o    = mem_req_q;
  assign mem_addr_o   = mem_addr_q;
  assign mem_wdata_o  = mem_wdata_q;
  assign wr_count_o   = wr_count_q;
  assign overrun_o    = overrun_q;

endmodule
`default_nettype wire

// File: tb/tb_i2s_capture_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_i2s_capture_ctrl
//  Description : Scoreboard bench for i2s_capture_ctrl with a show-ahead FIFO
//                model. BUF_AW=3, so cfg_len=0 means an 8-sample session.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_i2s_capture_ctrl;
  localparam int DW = 32;
  localparam int AW = 3;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start_i = 1'b0, abort_i = 1'b0, trig_i = 1'b0;
  logic [AW-1:0] len_i = '0;
  logic          fifo_full_i = 1'b0, avg_i = 1'b0, gnt_i = 1'b0;
  logic          fifo_empty;
  logic [DW-1:0] fifo_rdata;
  logic          i2s_en_o, fifo_flush_o, fifo_rd_o, mem_req_o, busy_o, done_o, overrun_o;
  logic [AW-1:0] mem_addr_o;
  logic [DW-1:0] mem_wdata_o;
  logic [AW:0]   wr_count_o;

  i2s_capture_ctrl #(.DW(DW), .BUF_AW(AW)) dut (
    .clk(clk), .rst(rst), .start_i(start_i), .abort_i(abort_i),
    .cfg_trig_en_i(trig_i), .cfg_len_i(len_i),
    .i2s_en_o(i2s_en_o), .fifo_flush_o(fifo_flush_o), .fifo_rd_o(fifo_rd_o),
    .fifo_empty_i(fifo_empty), .fifo_full_i(fifo_full_i), .fifo_rdata_i(fifo_rdata),
    .avg_flag_i(avg_i), .mem_req_o(mem_req_o), .mem_addr_o(mem_addr_o),
    .mem_wdata_o(mem_wdata_o), .mem_gnt_i(gnt_i), .busy_o(busy_o), .done_o(done_o),
    .overrun_o(overrun_o), .wr_count_o(wr_count_o)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // FIFO model: show-ahead head word, flush drops everything queued.
  logic [DW-1:0] fifo_mem [0:63];
  int wp = 0, rp = 0, rd_cnt = 0;
  assign fifo_empty = (wp == rp);
  assign fifo_rdata = fifo_mem[rp[5:0]];

  always @(posedge clk) begin
    if (fifo_flush_o) rp <= wp;
    else if (fifo_rd_o && (wp != rp)) begin
      rp     <= rp + 1;
      rd_cnt <= rd_cnt + 1;
    end
  end

  // Scoreboard of expected {addr, data} memory writes.
  logic [AW+DW-1:0] exp_q [$];
  bit req_seen = 0;
  int done_cnt = 0;

  // Monitor: compare every accepted write, check pops never hit an empty FIFO.
  always @(negedge clk) begin
    logic [AW+DW-1:0] e;
    if (mem_req_o && gnt_i) begin
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL unexpected_write: got addr=%0h data=%0h, none expected", mem_addr_o, mem_wdata_o);
      end else begin
        e = exp_q.pop_front();
        if ({mem_addr_o, mem_wdata_o} !== e) begin
          failures++;
          $display("FAIL write: got addr=%0h data=%0h expected addr=%0h data=%0h",
                   mem_addr_o, mem_wdata_o, e[AW+DW-1:DW], e[DW-1:0]);
        end
      end
    end
    if (fifo_rd_o) begin
      checks++;
      if (fifo_empty) begin
        failures++;
        $display("FAIL rd_on_empty: got fifo_rd=1 with empty FIFO, expected no pop");
      end
    end
    if (mem_req_o) req_seen = 1;
    if (done_o) done_cnt++;
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [DW-1:0] v);
    fifo_mem[wp % 64] = v;
    wp = wp + 1;
  endtask

  task automatic expect_wr(input logic [AW-1:0] a, input logic [DW-1:0] d);
    exp_q.push_back({a, d});
  endtask

  // Pulse start for one cycle; returns with the DUT in FLUSH.
  task automatic start_session(input logic trig, input logic [AW-1:0] len);
    trig_i  = trig;
    len_i   = len;
    start_i = 1'b1;
    step();
    start_i = 1'b0;
  endtask

  // Returns at the negedge of the DONE cycle; n = negedges waited, 0 on timeout.
  task automatic wait_done(input int budget, output int n);
    n = 0;
    for (int i = 1; i <= budget; i++) begin
      @(negedge clk);
      if (done_o) begin
        n = i;
        break;
      end
    end
    if (n == 0) begin
      checks++;
      failures++;
      $display("FAIL done_timeout: got no done within %0d cycles, expected done", budget);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got simulation still running, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, rd0, dc0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_outputs",
          {i2s_en_o, fifo_flush_o, fifo_rd_o, mem_req_o, mem_addr_o, mem_wdata_o,
           busy_o, done_o, overrun_o, wr_count_o}, 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    step();

    // 1: four back-to-back writes with gnt held high.
    gnt_i = 1'b1;
    start_session(1'b0, 3'd4);
    check("flush_state", {fifo_flush_o, i2s_en_o, busy_o}, 64'b101);
    step();
    push(32'h11); push(32'h22); push(32'h33); push(32'h44);
    expect_wr(3'd0, 32'h11); expect_wr(3'd1, 32'h22);
    expect_wr(3'd2, 32'h33); expect_wr(3'd3, 32'h44);
    wait_done(20, n);
    check("t1_latency", n, 6);
    check("t1_done_outputs", {i2s_en_o, mem_req_o, wr_count_o}, {2'b00, 4'd4});
    step();

    // 2: trigger mode discards samples until avg_flag.
    start_session(1'b1, 3'd2);
    step();
    rd0 = rd_cnt;
    req_seen = 0;
    push(32'h1); push(32'h2); push(32'h3);
    repeat (6) step();
    check("t2_discard_count", rd_cnt - rd0, 3);
    check("t2_no_req", req_seen, 0);
    check("t2_armed_en", {i2s_en_o, busy_o}, 64'b11);
    avg_i = 1'b1;
    step();
    avg_i = 1'b0;
    push(32'hA); push(32'hB);
    expect_wr(3'd0, 32'hA); expect_wr(3'd1, 32'hB);
    wait_done(20, n);
    check("t2_wr_count", wr_count_o, 2);
    step();

    // 3: gnt held low for 5 cycles keeps the write port frozen.
    gnt_i = 1'b0;
    start_session(1'b0, 3'd3);
    step();
    push(32'h31); push(32'h32); push(32'h33);
    expect_wr(3'd0, 32'h31); expect_wr(3'd1, 32'h32); expect_wr(3'd2, 32'h33);
    step();
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("t3_stall_hold", {mem_req_o, mem_addr_o, mem_wdata_o, fifo_rd_o},
            {1'b1, 3'd0, 32'h31, 1'b0});
      step();
    end
    gnt_i = 1'b1;
    wait_done(20, n);
    check("t3_wr_count", wr_count_o, 3);
    step();

    // 4: abort in the cycle of the 2nd gnt (len 0 = 8 samples).
    start_session(1'b0, 3'd0);
    step();
    for (int i = 0; i < 8; i++) push(32'h41 + i);
    expect_wr(3'd0, 32'h41); expect_wr(3'd1, 32'h42);
    step();
    step();
    dc0 = done_cnt;
    abort_i = 1'b1;
    step();
    abort_i = 1'b0;
    @(negedge clk);
    check("t4_after_abort", {busy_o, mem_req_o, i2s_en_o, done_o, wr_count_o},
          {4'b0000, 4'd2});
    repeat (3) step();
    check("t4_no_done", done_cnt - dc0, 0);
    start_session(1'b0, 3'd2);
    step();
    push(32'h51); push(32'h52);
    expect_wr(3'd0, 32'h51); expect_wr(3'd1, 32'h52);
    wait_done(20, n);
    check("t4_restart_count", wr_count_o, 2);
    step();

    // 5: one-cycle fifo_full in CAPTURE sets sticky overrun.
    start_session(1'b0, 3'd3);
    step();
    fifo_full_i = 1'b1;
    step();
    fifo_full_i = 1'b0;
    @(negedge clk);
    check("t5_overrun_set", overrun_o, 1);
    step();
    push(32'h61); push(32'h62); push(32'h63);
    expect_wr(3'd0, 32'h61); expect_wr(3'd1, 32'h62); expect_wr(3'd2, 32'h63);
    wait_done(20, n);
    check("t5_overrun_at_done", overrun_o, 1);
    step();
    @(negedge clk);
    check("t5_overrun_idle", {busy_o, overrun_o}, 64'b01);
    step();

    // 6a: accepted start clears overrun; start during CAPTURE is ignored.
    start_session(1'b0, 3'd4);
    @(negedge clk);
    check("t6_overrun_cleared", overrun_o, 0);
    step();
    push(32'h71); push(32'h72); push(32'h73); push(32'h74);
    expect_wr(3'd0, 32'h71); expect_wr(3'd1, 32'h72);
    expect_wr(3'd2, 32'h73); expect_wr(3'd3, 32'h74);
    len_i   = 3'd1;
    start_i = 1'b1;
    step();
    start_i = 1'b0;
    wait_done(20, n);
    check("t6_ignored_start_count", wr_count_o, 4);
    step();

    // 6b: rst mid-CAPTURE returns everything to zero.
    start_session(1'b0, 3'd0);
    step();
    for (int i = 0; i < 8; i++) push(32'h81 + i);
    expect_wr(3'd0, 32'h81); expect_wr(3'd1, 32'h82);
    step();
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    @(negedge clk);
    check("t6_rst_outputs",
          {i2s_en_o, fifo_flush_o, fifo_rd_o, mem_req_o, mem_addr_o, mem_wdata_o,
           busy_o, done_o, overrun_o, wr_count_o}, 64'd0);
    step();

    // 6c: len=0 captures the full 2**BUF_AW = 8 samples.
    start_session(1'b0, 3'd0);
    step();
    for (int i = 0; i < 8; i++) begin
      push(32'h91 + i);
      expect_wr(3'(i), 32'h91 + i);
    end
    wait_done(30, n);
    check("t6_full_latency", n, 10);
    check("t6_full_count", wr_count_o, 8);
    step();
    repeat (2) step();
    check("scoreboard_drained", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
`default_nettype wire
